difftest_log_event: RTL and testbench

Simulation-side performance-event sink that sits at the end of each `PERF` counter in the core. It samples a free-running 32-bit event counter every cycle and derives per-cycle increments, a 64-bit wrap-extended total, a peak per-cycle increment and fixed-interval window counts. When `DIFFTEST` logging is active, it reports each window and a final summary, tagged with the event name and core id. It has no effect on the core datapath; all outputs are observation-only.

---
 rtl/difftest_log_event.sv | 133 +++++++++++++
 tb/tb_difftest_log_event.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/difftest_log_event.sv
// ----------------------------------------------------------------------------
// difftest_log_event
//
// Observation-only performance-event sink. It samples a free-running 32-bit
// event counter every cycle and derives:
//   - the per-cycle increment (delta),
//   - a 64-bit wrap-extended running total,
//   - the largest per-cycle increment seen since reset,
//   - the increment sum over each fixed window of INTERVAL cycles.
// When DIFFTEST is defined, each completed window and a final summary are
// reported, tagged with NAME and the core id. Nothing here feeds back into
// the core datapath.
//
// Parameters:
//   NAME          string tag used in report lines
//   INTERVAL      window length in cycles (must be >= 1)
//
// Ports:
//   clk           core clock, rising-edge active
//   rst           asynchronous, active-low reset
//   coreid[7:0]   core index, report text only
//   value[31:0]   monitored event counter (monotonic modulo 2^32)
//   delta[31:0]   registered increment of value over the previous cycle
//   total[63:0]   registered running sum of all increments
//   max_delta     registered largest delta since reset (unsigned)
//   window_count  increment sum over the last completed window
//   window_valid  one-cycle pulse when window_count is updated
// ----------------------------------------------------------------------------
module difftest_log_event #(
    parameter     NAME     = "event",
    parameter int INTERVAL = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  coreid,
    input  logic [31:0] value,
    output logic [31:0] delta,
    output logic [63:0] total,
    output logic [31:0] max_delta,
    output logic [31:0] window_count,
    output logic        window_valid
);

    // A one-cycle window still needs a 1-bit counter that simply sits at 0.
    localparam int              CYC_W    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(INTERVAL - 1);

    logic [31:0]      last_value_reg, last_value_next;
    logic [31:0]      win_acc_reg,    win_acc_next;
    logic [CYC_W-1:0] cyc_reg,        cyc_next;
    logic [31:0]      delta_reg,      delta_next;
    logic [63:0]      total_reg,      total_next;
    logic [31:0]      max_delta_reg,  max_delta_next;
    logic [31:0]      window_count_reg, window_count_next;
    logic             window_valid_reg, window_valid_next;

    // Modulo-2^32 subtraction: a smaller value than last time is a counter
    // wrap, and the natural 32-bit borrow already yields value + 2^32 - last.
    logic [31:0] inc;
    assign inc = value - last_value_reg;

    always_comb begin
        last_value_next   = value;
        delta_next        = inc;
        total_next        = total_reg + {32'd0, inc};
        max_delta_next    = (inc > max_delta_reg) ? inc : max_delta_reg;
        window_count_next = window_count_reg;
        window_valid_next = 1'b0;
        win_acc_next      = win_acc_reg + inc;
        cyc_next          = cyc_reg + 1'b1;

        if (cyc_reg == CYC_LAST) begin
            // Close the window including this cycle's increment.
            window_count_next = win_acc_reg + inc;
            window_valid_next = 1'b1;
            win_acc_next      = 32'd0;
            cyc_next          = '0;
        end
    end

    // Reset clears everything at once; a partially filled window is simply
    // thrown away, so no pulse is issued for it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_value_reg   <= 32'd0;
            win_acc_reg      <= 32'd0;
            cyc_reg          <= '0;
            delta_reg        <= 32'd0;
            total_reg        <= 64'd0;
            max_delta_reg    <= 32'd0;
            window_count_reg <= 32'd0;
            window_valid_reg <= 1'b0;
        end else begin
            last_value_reg   <= last_value_next;
            win_acc_reg      <= win_acc_next;
            cyc_reg          <= cyc_next;
            delta_reg        <= delta_next;
            total_reg        <= total_next;
            max_delta_reg    <= max_delta_next;
            window_count_reg <= window_count_next;
            window_valid_reg <= window_valid_next;
        end
    end

    assign delta        = delta_reg;
    assign total        = total_reg;
    assign max_delta    = max_delta_reg;
    assign window_count = window_count_reg;
    assign window_valid = window_valid_reg;

    // coreid and NAME only matter to the report text; keep them referenced
    // so builds without reporting stay warning-free.
    logic                     unused_coreid;
    logic [$bits(NAME)-1:0]   unused_name_bits;
    assign unused_coreid    = ^coreid;
    assign unused_name_bits = NAME;

`ifdef DIFFTEST
    // Sampled at the edge after the window closed, so window_count and
    // total show the values registered on the closing edge.
    always @(posedge clk) begin
        if (rst && window_valid_reg && DLog::logValid) begin
            $display("[%16d] core%0d %s window=%0d total=%0d",
                     DLog::cycleCnt, coreid, NAME, window_count_reg, total_reg);
        end
    end

    final begin
        $display("core%0d %s total=%0d max=%0d", coreid, NAME, total_reg, max_delta_reg);
    end
`endif

endmodule

// File: tb/tb_difftest_log_event.sv
// ----------------------------------------------------------------------------
// Directed bench for difftest_log_event. Three instances share clock, reset
// and value stimulus, differing only in INTERVAL (4, 8, 1); each scenario
// task checks the instance relevant to it against hand-computed constants.
// ----------------------------------------------------------------------------
module tb_difftest_log_event;

    logic        clk;
    logic        rst;
    logic [7:0]  coreid;
    logic [31:0] value;

    logic [31:0] delta4, max4, wcnt4;
    logic [63:0] total4;
    logic        wval4;
    logic [31:0] delta8, max8, wcnt8;
    logic [63:0] total8;
    logic        wval8;
    logic [31:0] delta1, max1, wcnt1;
    logic [63:0] total1;
    logic        wval1;

    int pass_cnt = 0;
    int total_cnt = 0;

    difftest_log_event #(.NAME("ev4"), .INTERVAL(4)) dut4 (
        .clk(clk), .rst(rst), .coreid(coreid), .value(value),
        .delta(delta4), .total(total4), .max_delta(max4),
        .window_count(wcnt4), .window_valid(wval4)
    );

    difftest_log_event #(.NAME("ev8"), .INTERVAL(8)) dut8 (
        .clk(clk), .rst(rst), .coreid(coreid), .value(value),
        .delta(delta8), .total(total8), .max_delta(max8),
        .window_count(wcnt8), .window_valid(wval8)
    );

    difftest_log_event #(.NAME("ev1"), .INTERVAL(1)) dut1 (
        .clk(clk), .rst(rst), .coreid(coreid), .value(value),
        .delta(delta1), .total(total1), .max_delta(max1),
        .window_count(wcnt1), .window_valid(wval1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with v already on value; release just after an edge so the next
    // edge is the first one after release.
    task automatic restart(input logic [31:0] v);
        value = v;
        rst   = 1'b0;
        tick();
        tick();
        rst   = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst   = 1'b0;
        value = 32'd5;
        #1;
        total_cnt++; if (delta4 !== 32'd0) $display("FAIL reset_delta got=%0h exp=0", delta4); else pass_cnt++;
        total_cnt++; if (total4 !== 64'd0) $display("FAIL reset_total got=%0h exp=0", total4); else pass_cnt++;
        total_cnt++; if (max4 !== 32'd0) $display("FAIL reset_max got=%0h exp=0", max4); else pass_cnt++;
        total_cnt++; if (wcnt4 !== 32'd0) $display("FAIL reset_wcnt got=%0h exp=0", wcnt4); else pass_cnt++;
        total_cnt++; if (wval4 !== 1'b0) $display("FAIL reset_wval got=%0b exp=0", wval4); else pass_cnt++;
        total_cnt++; if (wval1 !== 1'b0) $display("FAIL reset_wval1 got=%0b exp=0", wval1); else pass_cnt++;
        tick();
        rst = 1'b1;
        tick();
        total_cnt++; if (delta4 !== 32'd5) $display("FAIL reset_first_delta got=%0d exp=5", delta4); else pass_cnt++;
        total_cnt++; if (total4 !== 64'd5) $display("FAIL reset_first_total got=%0d exp=5", total4); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_steady();
        restart(32'd3);
        for (int k = 1; k <= 12; k++) begin
            tick();
            total_cnt++; if (delta4 !== 32'd3) $display("FAIL steady_delta k=%0d got=%0d exp=3", k, delta4); else pass_cnt++;
            total_cnt++; if (total4 !== 64'(3 * k)) $display("FAIL steady_total k=%0d got=%0d exp=%0d", k, total4, 3 * k); else pass_cnt++;
            total_cnt++; if (wval4 !== ((k % 4) == 0)) $display("FAIL steady_wval k=%0d got=%0b exp=%0b", k, wval4, (k % 4) == 0); else pass_cnt++;
            if ((k % 4) == 0) begin
                total_cnt++; if (wcnt4 !== 32'd12) $display("FAIL steady_wcnt k=%0d got=%0d exp=12", k, wcnt4); else pass_cnt++;
            end
            value = value + 32'd3;
        end
        $display("test_steady done");
    endtask

    task automatic test_wrap();
        restart(32'hFFFF_FFFE);
        tick();
        total_cnt++; if (total4 !== 64'h0000_0000_FFFF_FFFE) $display("FAIL wrap_total0 got=%0h exp=fffffffe", total4); else pass_cnt++;
        value = 32'h0000_0001;
        tick();
        total_cnt++; if (delta4 !== 32'd3) $display("FAIL wrap_delta got=%0h exp=3", delta4); else pass_cnt++;
        total_cnt++; if (total4 !== 64'h0000_0001_0000_0001) $display("FAIL wrap_total got=%0h exp=100000001", total4); else pass_cnt++;
        total_cnt++; if (max4 !== 32'hFFFF_FFFE) $display("FAIL wrap_max got=%0h exp=fffffffe", max4); else pass_cnt++;
        $display("test_wrap done");
    endtask

    task automatic test_peak();
        logic [31:0] seq [4];
        logic [31:0] exp_max [4];
        seq     = '{32'd1, 32'd10, 32'd12, 32'd12};
        exp_max = '{32'd1, 32'd9, 32'd9, 32'd9};
        restart(seq[0]);
        for (int i = 0; i < 4; i++) begin
            value = seq[i];
            tick();
            total_cnt++; if (max4 !== exp_max[i]) $display("FAIL peak_max i=%0d got=%0d exp=%0d", i, max4, exp_max[i]); else pass_cnt++;
        end
        total_cnt++; if (total4 !== 64'd12) $display("FAIL peak_total got=%0d exp=12", total4); else pass_cnt++;
        $display("test_peak done");
    endtask

    task automatic test_mid_reset();
        restart(32'd1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            value = value + 32'd1;
        end
        #2;
        rst = 1'b0;
        #1;
        total_cnt++; if (total8 !== 64'd0) $display("FAIL midrst_async_total got=%0d exp=0", total8); else pass_cnt++;
        total_cnt++; if (delta8 !== 32'd0) $display("FAIL midrst_async_delta got=%0d exp=0", delta8); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++; if (wval8 !== 1'b0) $display("FAIL midrst_held_wval k=%0d got=%0b exp=0", k, wval8); else pass_cnt++;
        end
        value = 32'd0;
        rst   = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            total_cnt++; if (wval8 !== (k == 8)) $display("FAIL midrst_wval k=%0d got=%0b exp=%0b", k, wval8, k == 8); else pass_cnt++;
            if (k == 8) begin
                total_cnt++; if (wcnt8 !== 32'd7) $display("FAIL midrst_wcnt got=%0d exp=7", wcnt8); else pass_cnt++;
            end
            value = value + 32'd1;
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_constant();
        restart(32'd7);
        for (int k = 1; k <= 8; k++) begin
            tick();
            total_cnt++; if (total4 !== 64'd7) $display("FAIL const_total k=%0d got=%0d exp=7", k, total4); else pass_cnt++;
            if (k == 2) begin
                total_cnt++; if (delta4 !== 32'd0) $display("FAIL const_delta got=%0d exp=0", delta4); else pass_cnt++;
            end
            if (k == 4) begin
                total_cnt++; if (wval4 !== 1'b1 || wcnt4 !== 32'd7) $display("FAIL const_win1 got=%0b/%0d exp=1/7", wval4, wcnt4); else pass_cnt++;
            end
            if (k == 8) begin
                total_cnt++; if (wval4 !== 1'b1 || wcnt4 !== 32'd0) $display("FAIL const_win2 got=%0b/%0d exp=1/0", wval4, wcnt4); else pass_cnt++;
            end
        end
        $display("test_constant done");
    endtask

    task automatic test_interval1();
        restart(32'd2);
        for (int k = 1; k <= 6; k++) begin
            tick();
            total_cnt++; if (wval1 !== 1'b1) $display("FAIL int1_wval k=%0d got=%0b exp=1", k, wval1); else pass_cnt++;
            total_cnt++; if (wcnt1 !== 32'd2) $display("FAIL int1_wcnt k=%0d got=%0d exp=2", k, wcnt1); else pass_cnt++;
            total_cnt++; if (delta1 !== 32'd2) $display("FAIL int1_delta k=%0d got=%0d exp=2", k, delta1); else pass_cnt++;
            value = value + 32'd2;
        end
        $display("test_interval1 done");
    endtask

    initial begin
        rst    = 1'b1;
        coreid = 8'd3;
        value  = 32'd0;
        test_reset();
        test_steady();
        test_wrap();
        test_peak();
        test_mid_reset();
        test_constant();
        test_interval1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
